sqrt_seq: RTL and testbench

//   Sequential unsigned integer square root; the inverse of the full-width unsigned squarer.

---
 rtl/sqrt_seq_if.sv | 9 +
 rtl/sqrt_seq.sv | 68 ++++++
 tb/tb_sqrt_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_if.sv
// sqrt_seq_if: radicand-in / root-and-remainder-out valid/ready bundle
interface sqrt_seq_if #(parameter int LEN = 16);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [2*LEN-1:0] x;
  logic [LEN-1:0] y;
  logic [LEN:0] r;
  modport master(output in_valid, x, out_ready, input in_ready, out_valid, y, r);
  modport slave(input in_valid, x, out_ready, output in_ready, out_valid, y, r);
endinterface

// File: rtl/sqrt_seq.sv
// sqrt_seq: restoring digit-by-digit integer square root, one root bit per clock
module sqrt_seq #(
  parameter int LEN = 16
) (
  input logic clk,
  input logic rst_n,
  sqrt_seq_if.slave bus
);
  localparam int CW = $clog2(LEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t r_state;
  logic [2*LEN-1:0] r_x;
  logic [LEN+1:0] r_rem;
  logic [LEN-1:0] r_root;
  logic [CW-1:0] r_cnt;
  logic [LEN-1:0] r_y;
  logic [LEN:0] r_r;
  logic [LEN+1:0] w_rem2, w_trial, w_rem_n;
  logic [LEN-1:0] w_root_n;
  logic w_ge, w_accept;
  assign w_rem2 = (r_rem << 2) | (LEN+2)'(r_x[2*LEN-1 -: 2]);
  assign w_trial = {r_root, 2'b01};
  assign w_ge = w_rem2 >= w_trial;
  assign w_rem_n = w_ge ? w_rem2 - w_trial : w_rem2;
  assign w_root_n = {r_root[LEN-2:0], w_ge};
  assign bus.in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
  assign w_accept = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_state == DONE;
  assign bus.y = r_y;
  assign bus.r = r_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x <= '0;
      r_rem <= '0;
      r_root <= '0;
      r_cnt <= '0;
      r_y <= '0;
      r_r <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_x <= bus.x;
            r_rem <= '0;
            r_root <= '0;
            r_cnt <= CW'(LEN - 1);
            r_state <= CALC;
          end else if (r_state == DONE && bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_x <= r_x << 2;
          r_rem <= w_rem_n;
          r_root <= w_root_n;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= DONE;
            r_y <= w_root_n;
            r_r <= w_rem_n[LEN:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_seq.sv
// tb_sqrt_seq: randomized and directed checks of sqrt_seq against an arithmetic isqrt model
module tb_sqrt_seq;
  localparam int LEN = 16;
  logic clk = 0;
  logic rst_n, rst_s_n;
  int tests = 0, fails = 0, cyc = 0;
  bit rnd_on = 0, done2 = 0, done7 = 0;
  longint qx[$];
  longint qt[$];
  always #5 clk = ~clk;
  sqrt_seq_if #(.LEN(LEN)) b();
  sqrt_seq_if #(.LEN(2)) b2();
  sqrt_seq_if #(.LEN(7)) b7();
  sqrt_seq #(.LEN(LEN)) dut(.clk(clk), .rst_n(rst_n), .bus(b));
  sqrt_seq #(.LEN(2)) dut2(.clk(clk), .rst_n(rst_s_n), .bus(b2));
  sqrt_seq #(.LEN(7)) dut7(.clk(clk), .rst_n(rst_s_n), .bus(b7));
  function automatic longint isqrt(input longint x);
    longint lo = 0, hi = 65536, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic ev;
    longint ey;
    cyc++;
    if (!rst_n) begin
      qx.delete();
      qt.delete();
      check("rst_out_valid", b.out_valid, 0);
      check("rst_y", b.y, 0);
      check("rst_r", b.r, 0);
    end else begin
      ev = qx.size() > 0 && cyc - qt[0] >= LEN + 1;
      check("out_valid", b.out_valid, ev);
      check("in_ready", b.in_ready, qx.size() == 0 || (ev && b.out_ready));
      if (ev && b.out_valid) begin
        ey = isqrt(qx[0]);
        check("y", b.y, ey);
        check("r", b.r, qx[0] - ey * ey);
        check("y2_plus_r", longint'(b.y) * longint'(b.y) + longint'(b.r), qx[0]);
        check("r_le_2y", longint'(b.r) <= 2 * longint'(b.y), 1);
        if (b.out_ready) begin
          void'(qx.pop_front());
          void'(qt.pop_front());
        end
      end
      if (b.in_valid && b.in_ready) begin
        qx.push_back(longint'(b.x));
        qt.push_back(cyc);
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_on) b.out_ready = ($urandom_range(0, 3) != 0);
  end
  task automatic send(input logic [31:0] x, output time t);
    int n = 0;
    b.x = x;
    b.in_valid = 1;
    @(negedge clk);
    while (!b.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b.in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for x=%0d", x);
    end
    t = $time;
    @(posedge clk);
    #1 b.in_valid = 0;
  endtask
  task automatic wait_out(output time t);
    int n = 0;
    @(negedge clk);
    while (!b.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b.out_valid) begin
      tests++;
      fails++;
      $display("FAIL out_timeout: out_valid stayed 0");
    end
    t = $time;
  endtask
  task automatic run(input logic [31:0] x, input longint ey, input longint er, input int hold);
    time ta, to;
    b.out_ready = (hold == 0);
    send(x, ta);
    wait_out(to);
    check("latency", (to - ta) / 10, LEN + 1);
    check("dir_y", b.y, ey);
    check("dir_r", b.r, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", b.out_valid, 1);
      check("hold_y", b.y, ey);
      check("hold_r", b.r, er);
      check("hold_in_ready", b.in_ready, 0);
    end
    b.out_ready = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    b2.in_valid = 0; b2.x = '0; b2.out_ready = 1;
    wait (rst_s_n);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      int n;
      longint e;
      b2.x = 4'(i);
      b2.in_valid = 1;
      n = 0;
      @(negedge clk);
      while (!b2.in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 b2.in_valid = 0;
      n = 0;
      @(negedge clk);
      while (!b2.out_valid && n < 50) begin @(negedge clk); n++; end
      e = isqrt(i);
      check("l2_y", b2.y, e);
      check("l2_r", b2.r, i - e * e);
    end
    done2 = 1;
  end
  initial begin
    b7.in_valid = 0; b7.x = '0; b7.out_ready = 1;
    wait (rst_s_n);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      int n;
      longint e, xv;
      xv = (i == 0) ? 16383 : (i == 1) ? 0 : longint'($urandom_range(0, 16383));
      b7.x = 14'(xv);
      b7.in_valid = 1;
      n = 0;
      @(negedge clk);
      while (!b7.in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 b7.in_valid = 0;
      n = 0;
      @(negedge clk);
      while (!b7.out_valid && n < 50) begin @(negedge clk); n++; end
      e = isqrt(xv);
      check("l7_y", b7.y, e);
      check("l7_r", b7.r, xv - e * e);
    end
    done7 = 1;
  end
  initial begin
    time t1, t2, to;
    rst_n = 0; rst_s_n = 0;
    b.in_valid = 0; b.x = '0; b.out_ready = 1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1; rst_s_n = 1;
    @(negedge clk);
    check("in_ready_after_reset", b.in_ready, 1);
    check("model_pin_200", isqrt(200), 14);
    check("model_pin_1000", isqrt(1000), 31);
    check("model_pin_max", isqrt(64'hFFFF_FFFF), 65535);
    @(posedge clk);
    #1;
    run(0, 0, 0, 0);
    run(144, 12, 0, 0);
    run(200, 14, 4, 0);
    run(32'hFFFF_FFFF, 16'hFFFF, 17'h1_FFFE, 0);
    run(1, 1, 0, 0);
    run(1000, 31, 39, 5);
    b.out_ready = 1;
    send(49, t1);
    b.x = 50;
    b.in_valid = 1;
    @(negedge clk);
    while (!b.in_ready && (($time - t1) / 10) < 100) @(negedge clk);
    t2 = $time;
    check("b2b_interval", (t2 - t1) / 10, LEN + 1);
    check("b2b_y0", b.y, 7);
    check("b2b_r0", b.r, 0);
    @(posedge clk);
    #1 b.in_valid = 0;
    wait_out(to);
    check("b2b_y1", b.y, 7);
    check("b2b_r1", b.r, 1);
    @(posedge clk);
    #1;
    send(65536, t1);
    repeat (7) @(posedge clk);
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("abort_in_ready", b.in_ready, 1);
    check("abort_y", b.y, 0);
    check("abort_r", b.r, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_valid", b.out_valid, 0);
    end
    @(posedge clk);
    #1;
    run(65536, 256, 0, 0);
    rnd_on = 1;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] xr;
      logic [15:0] y0;
      y0 = 16'($urandom);
      xr = (i % 4 == 0) ? 32'(y0) * 32'(y0) : 32'($urandom);
      send(xr, t1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rnd_on = 0;
    b.out_ready = 1;
    repeat (40) @(negedge clk);
    check("drained", qx.size(), 0);
    for (int i = 0; i < 5000 && !(done2 && done7); i++) @(negedge clk);
    check("small_len_done", {done2, done7}, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
